// File: rtl/hazard_pkg.sv
// Shared encodings, E-stage shadow record and the forwarding-select helper
// used by the hazard scoreboard.
package hazard_pkg;

  localparam int unsigned ARCH_AW = 5;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef struct packed {
    logic [ARCH_AW-1:0] rs1;
    logic [ARCH_AW-1:0] rs2;
    logic [ARCH_AW-1:0] rd;
    logic               regwrite;
    logic               isload;
  } stage_e_t;

  // M outranks W because it carries the younger value of the register
  function automatic logic [1:0] fwd_sel(
    input logic [ARCH_AW-1:0] src,
    input logic [ARCH_AW-1:0] rd_m,
    input logic               rw_m,
    input logic [ARCH_AW-1:0] rd_w,
    input logic               rw_w
  );
    if (rw_m && (rd_m != '0) && (rd_m == src))
      return FWD_MEM;
    else if (rw_w && (rd_w != '0) && (rd_w == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating event counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: E/M/W shadow pipeline, operand
// forwarding selects, load-use stall, branch flush and event counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_e_t          e_q, e_d;
  logic [REG_AW-1:0] rd_m_q, rd_w_q;
  logic              rw_m_q, rw_w_q;
  logic              lwstall;

  always_comb begin
    e_d = '0;
    if (!FlushE) begin
      e_d.rs1      = Rs1D;
      e_d.rs2      = Rs2D;
      e_d.rd       = RdD;
      e_d.regwrite = RegWriteD;
      e_d.isload   = (ResultSrcD == RES_LOAD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      rd_m_q <= '0;
      rw_m_q <= 1'b0;
      rd_w_q <= '0;
      rw_w_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      rd_m_q <= e_q.rd;
      rw_m_q <= e_q.regwrite;
      rd_w_q <= rd_m_q;
      rw_w_q <= rw_m_q;
    end
  end

  assign ForwardAE = fwd_sel(e_q.rs1, rd_m_q, rw_m_q, rd_w_q, rw_w_q);
  assign ForwardBE = fwd_sel(e_q.rs2, rd_m_q, rw_m_q, rd_w_q, rw_w_q);

  // Raw rs2 compare even for instructions that ignore rs2: conservative stall
  assign lwstall = e_q.isload && (e_q.rd != '0) &&
                   ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

  assign StallF = lwstall && !PCSrcE;
  assign StallD = lwstall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = lwstall || PCSrcE;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc_i (StallD),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc_i (FlushD),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios plus
// random traffic, compared against an instruction-history reference model.
module tb_hazard_scoreboard;

  localparam int unsigned CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             PCSrcE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_scoreboard #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .PCSrcE     (PCSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs1, rs2, rd, rw, ld;
  } ins_t;

  typedef struct {
    string tag;
    int fa, fb, sf, sd, fd, fe, sc, fc;
  } exp_t;

  ins_t hist[$];  // instructions that entered E, newest first: E, M, W
  exp_t exp_q[$];
  int   m_sc, m_fc;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b = '{rs1: 0, rs2: 0, rd: 0, rw: 0, ld: 0};
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(bubble());
    m_sc = 0;
    m_fc = 0;
  endtask

  // Select for one source: the most recent older writer of that register wins
  function automatic int ref_fwd(input int src);
    if (hist[1].rw != 0 && hist[1].rd != 0 && hist[1].rd == src) return 2;
    if (hist[2].rw != 0 && hist[2].rd != 0 && hist[2].rd == src) return 1;
    return 0;
  endfunction

  task automatic step(input string tag, input int rs1, input int rs2, input int rd,
                      input int rw, input int rsrc, input int pc);
    exp_t e;
    ins_t d;
    int   lw;
    Rs1D = 5'(rs1); Rs2D = 5'(rs2); RdD = 5'(rd);
    RegWriteD = (rw != 0); ResultSrcD = 2'(rsrc); PCSrcE = (pc != 0);
    lw = (hist[0].ld != 0 && hist[0].rd != 0 &&
          (hist[0].rd == rs1 || hist[0].rd == rs2)) ? 1 : 0;
    e.tag = tag;
    e.fa = ref_fwd(hist[0].rs1);
    e.fb = ref_fwd(hist[0].rs2);
    e.sf = (lw != 0 && pc == 0) ? 1 : 0;
    e.sd = e.sf;
    e.fd = pc;
    e.fe = (lw != 0 || pc != 0) ? 1 : 0;
    e.sc = m_sc;
    e.fc = m_fc;
    exp_q.push_back(e);
    if (e.sd != 0 && m_sc < MAXC) m_sc++;
    if (e.fd != 0 && m_fc < MAXC) m_fc++;
    d = '{rs1: rs1, rs2: rs2, rd: rd, rw: rw, ld: (rsrc == 1) ? 1 : 0};
    hist.push_front(e.fe != 0 ? bubble() : d);
    void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step("nop", 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".ForwardAE"}, int'(ForwardAE), e.fa);
        chk({e.tag, ".ForwardBE"}, int'(ForwardBE), e.fb);
        chk({e.tag, ".StallF"},    int'(StallF),    e.sf);
        chk({e.tag, ".StallD"},    int'(StallD),    e.sd);
        chk({e.tag, ".FlushD"},    int'(FlushD),    e.fd);
        chk({e.tag, ".FlushE"},    int'(FlushE),    e.fe);
        chk({e.tag, ".stall_cnt"}, int'(stall_cnt), e.sc);
        chk({e.tag, ".flush_cnt"}, int'(flush_cnt), e.fc);
      end
    end
  end

  initial begin : stimulus
    exp_t z;
    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; ResultSrcD = '0; PCSrcE = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    z = '{tag: "reset", fa: 0, fb: 0, sf: 0, sd: 0, fd: 0, fe: 0, sc: 0, fc: 0};
    exp_q.push_back(z);
    @(posedge clk);
    #1;
    reset = 1'b0;

    step("add_x5", 1, 2, 5, 1, 0, 0);
    step("sub_x6", 5, 3, 6, 1, 0, 0);
    nop(); nop();

    step("add_x5", 1, 2, 5, 1, 0, 0);
    step("unrel", 9, 10, 11, 1, 0, 0);
    step("or_x7", 4, 5, 7, 1, 0, 0);
    nop(); nop();
    step("add_x0", 1, 2, 0, 1, 0, 0);
    step("use_x0a", 0, 0, 7, 1, 0, 0);
    step("use_x0b", 0, 0, 8, 1, 0, 0);
    nop(); nop();

    step("lw_x8", 1, 0, 8, 1, 1, 0);
    step("add_x9", 8, 8, 9, 1, 0, 0);
    step("add_x9r", 8, 8, 9, 1, 0, 0);
    nop(); nop();

    step("branch", 3, 4, 12, 1, 0, 1);
    nop(); nop(); nop();

    step("lw_x8b", 1, 0, 8, 1, 1, 0);
    step("lu_br", 8, 8, 9, 1, 0, 1);
    nop(); nop();

    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 1 : 0);
    nop(); nop();

    for (int i = 0; i < MAXC + 4; i++) begin
      step("sat_lw", 1, 0, 8, 1, 1, 0);
      step("sat_use", 8, 8, 9, 1, 0, 0);
    end
    nop();
    chk("stall_cnt_saturated", int'(stall_cnt), MAXC);

    step("pre_add", 1, 2, 5, 1, 0, 0);
    step("pre_sub", 5, 3, 6, 1, 0, 0);
    chk("pre_reset.ForwardAE", int'(ForwardAE), ref_fwd(hist[0].rs1));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst.ForwardAE", int'(ForwardAE), 0);
    chk("async_rst.ForwardBE", int'(ForwardBE), 0);
    chk("async_rst.stall_cnt", int'(stall_cnt), 0);
    chk("async_rst.flush_cnt", int'(flush_cnt), 0);
    chk("async_rst.FlushE",    int'(FlushE),    0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst", 5, 5, 6, 1, 0, 0);
    step("post_rst2", 5, 6, 7, 1, 0, 0);
    nop(); nop();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
